// File: rtl/writeback_queue_if.sv
// Port bundle for writeback_queue: execute-stage result handshake, register-file
// write port, pending-register scoreboard and occupancy.
interface writeback_queue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_data;
    logic            wb_stall;
    logic            wb_wen;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_din;
    logic [31:0]     pend;
    logic [3:0]      count;

    modport master (
        output in_valid, in_rd, in_data, wb_stall,
        input  in_ready, wb_wen, wb_rd, wb_din, pend, count
    );

    modport slave (
        input  in_valid, in_rd, in_data, wb_stall,
        output in_ready, wb_wen, wb_rd, wb_din, pend, count
    );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback queue draining one result per cycle into the register file.
// Macro WB_FWD_EN adds a two-port combinational forwarding lookup.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input logic              clk,
    input logic              rst_n,
    writeback_queue_if.slave wq
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]       fwd_rs1,
    input  logic [4:0]       fwd_rs2,
    output logic             fwd_hit1,
    output logic             fwd_hit2,
    output logic [XLEN-1:0]  fwd_data1,
    output logic [XLEN-1:0]  fwd_data2
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [3:0]      cnt;
    logic [DEPTH-1:0] ent_valid;
    logic [4:0]      ent_rd   [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];
    logic            out_wen;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_din;
    logic [31:0]     pend_vec;
    logic            ready;
    logic            push;
    logic            pop;

    // Handshake: a result transfers on a rising edge where in_valid && in_ready.
    // in_ready comes only from the registered count, never from in_valid; a
    // transfer with in_rd == 0 completes but is discarded.
    assign ready = (cnt < 4'(DEPTH));
    assign push  = wq.in_valid && ready && (wq.in_rd != 5'd0);
    assign pop   = (cnt != 4'd0) && !wq.wb_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ent_valid <= '0;
            out_wen   <= 1'b0;
            out_rd    <= '0;
            out_din   <= '0;
        end else begin
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
                out_rd            <= ent_rd[rd_ptr];
                out_din           <= ent_data[rd_ptr];
            end
            out_wen <= pop;
            case ({push, pop})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload is only ever read through a set valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[wr_ptr]   <= wq.in_rd;
            ent_data[wr_ptr] <= wq.in_data;
        end
    end

    always_comb begin
        pend_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) pend_vec[ent_rd[i]] = 1'b1;
        end
        if (out_wen) pend_vec[out_rd] = 1'b1;
        pend_vec[0] = 1'b0;
    end

    assign wq.in_ready = ready;
    assign wq.wb_wen   = out_wen;
    assign wq.wb_rd    = out_rd;
    assign wq.wb_din   = out_din;
    assign wq.pend     = pend_vec;
    assign wq.count    = cnt;

`ifdef WB_FWD_EN
    logic [4:0]  fwd_rs  [2];
    logic [XLEN:0] fwd_res [2];

    assign fwd_rs[0] = fwd_rs1;
    assign fwd_rs[1] = fwd_rs2;

    // Walk oldest to youngest (output stage, then head..tail) so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            fwd_res[p] = '0;
            if (out_wen && (out_rd == fwd_rs[p])) fwd_res[p] = {1'b1, out_din};
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if (ent_valid[idx] && (ent_rd[idx] == fwd_rs[p])) fwd_res[p] = {1'b1, ent_data[idx]};
            end
            if (fwd_rs[p] == 5'd0) fwd_res[p] = '0;
        end
    end

    assign fwd_hit1  = fwd_res[0][XLEN];
    assign fwd_data1 = fwd_res[0][XLEN-1:0];
    assign fwd_hit2  = fwd_res[1][XLEN];
    assign fwd_data2 = fwd_res[1][XLEN-1:0];
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model (forwarding checks when WB_FWD_EN is set).
module tb_writeback_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    writeback_queue_if #(.XLEN(XLEN)) wq ();

`ifdef WB_FWD_EN
    logic [4:0]      fwd_rs1 = '0;
    logic [4:0]      fwd_rs2 = '0;
    logic            fwd_hit1;
    logic            fwd_hit2;
    logic [XLEN-1:0] fwd_data1;
    logic [XLEN-1:0] fwd_data2;
`endif

    writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wq    (wq)
`ifdef WB_FWD_EN
        ,
        .fwd_rs1   (fwd_rs1),
        .fwd_rs2   (fwd_rs2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];   // {rd, data}, oldest first
    logic        m_wen = 1'b0;
    logic [4:0]  m_rd  = '0;
    logic [31:0] m_din = '0;

    task automatic model_reset();
        exp_q.delete();
        m_wen = 1'b0;
        m_rd  = '0;
        m_din = '0;
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] p;
        p = '0;
        foreach (exp_q[i]) p[exp_q[i][36:32]] = 1'b1;
        if (m_wen) p[m_rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // {hit, data}: youngest queued write wins, output stage is the oldest candidate.
    function automatic logic [32:0] model_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i][36:32] == rs) return {1'b1, exp_q[i][31:0]};
        end
        if (m_wen && m_rd == rs) return {1'b1, m_din};
        return '0;
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic st);
        bit full;
        bit do_pop;
        wq.in_valid = v;
        wq.in_rd    = rd;
        wq.in_data  = d;
        wq.wb_stall = st;
        @(posedge clk);
        full   = (exp_q.size() >= DEPTH);
        do_pop = (exp_q.size() > 0) && !st;
        if (do_pop) begin
            m_rd  = exp_q[0][36:32];
            m_din = exp_q[0][31:0];
            void'(exp_q.pop_front());
        end
        m_wen = do_pop;
        if (v && !full && rd != 5'd0) exp_q.push_back({rd, d});
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        wq.in_valid = 1'b0; wq.in_rd = '0; wq.in_data = '0; wq.wb_stall = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (wq.wb_wen !== 1'b0) begin n_err++; $display("FAIL reset_wb_wen got %0h want 0", wq.wb_wen); end
        n_vec++; if (wq.wb_rd !== 5'd0) begin n_err++; $display("FAIL reset_wb_rd got %0h want 0", wq.wb_rd); end
        n_vec++; if (wq.wb_din !== 32'd0) begin n_err++; $display("FAIL reset_wb_din got %0h want 0", wq.wb_din); end
        n_vec++; if (wq.pend !== 32'd0) begin n_err++; $display("FAIL reset_pend got %0h want 0", wq.pend); end
        n_vec++; if (wq.count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", wq.count); end
        n_vec++; if (wq.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0h want 1", wq.in_ready); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        n_vec++; if (wq.wb_wen !== 1'b0) begin n_err++; $display("FAIL single_e1_wen got %0h want 0", wq.wb_wen); end
        n_vec++; if (wq.pend !== 32'h20) begin n_err++; $display("FAIL single_e1_pend got %0h want 20", wq.pend); end
        n_vec++; if (wq.count !== 4'd1) begin n_err++; $display("FAIL single_e1_count got %0d want 1", wq.count); end
        cycle(1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if (wq.wb_wen !== 1'b1) begin n_err++; $display("FAIL single_e2_wen got %0h want 1", wq.wb_wen); end
        n_vec++; if (wq.wb_rd !== 5'd5) begin n_err++; $display("FAIL single_e2_rd got %0d want 5", wq.wb_rd); end
        n_vec++; if (wq.wb_din !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_e2_din got %0h want deadbeef", wq.wb_din); end
        n_vec++; if (wq.pend !== 32'h20) begin n_err++; $display("FAIL single_e2_pend got %0h want 20", wq.pend); end
        cycle(1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if (wq.wb_wen !== 1'b0) begin n_err++; $display("FAIL single_e3_wen got %0h want 0", wq.wb_wen); end
        n_vec++; if (wq.pend !== 32'h0) begin n_err++; $display("FAIL single_e3_pend got %0h want 0", wq.pend); end
        n_vec++; if (wq.wb_rd !== 5'd5) begin n_err++; $display("FAIL single_e3_rd_hold got %0d want 5", wq.wb_rd); end
    endtask

    task automatic test_fill_order();
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 5'(i), 32'(i * 17), 1'b1);
            if (i == 4) begin
                n_vec++; if (wq.in_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got %0h want 0", wq.in_ready); end
                n_vec++; if (wq.count !== 4'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", wq.count); end
            end
        end
        n_vec++; if (wq.count !== 4'd4) begin n_err++; $display("FAIL fill_over_count got %0d want 4", wq.count); end
        n_vec++; if (wq.pend !== 32'h1E) begin n_err++; $display("FAIL fill_pend got %0h want 1e", wq.pend); end
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0);
            n_vec++; if (wq.wb_wen !== 1'b1) begin n_err++; $display("FAIL drain_wen[%0d] got %0h want 1", i, wq.wb_wen); end
            n_vec++; if (wq.wb_rd !== 5'(i)) begin n_err++; $display("FAIL drain_rd[%0d] got %0d want %0d", i, wq.wb_rd, i); end
            n_vec++; if (wq.wb_din !== 32'(i * 17)) begin n_err++; $display("FAIL drain_din[%0d] got %0h want %0h", i, wq.wb_din, i * 17); end
        end
        cycle(1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if (wq.wb_wen !== 1'b0) begin n_err++; $display("FAIL drain_end_wen got %0h want 0", wq.wb_wen); end
        n_vec++; if (wq.count !== 4'd0) begin n_err++; $display("FAIL drain_end_count got %0d want 0", wq.count); end
    endtask

    task automatic test_x0_drop();
        n_vec++; if (wq.in_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got %0h want 1", wq.in_ready); end
        cycle(1'b1, 5'd0, 32'h1234, 1'b0);
        n_vec++; if (wq.count !== 4'd0) begin n_err++; $display("FAIL x0_count got %0d want 0", wq.count); end
        n_vec++; if (wq.pend !== 32'd0) begin n_err++; $display("FAIL x0_pend got %0h want 0", wq.pend); end
        cycle(1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if (wq.wb_wen !== 1'b0) begin n_err++; $display("FAIL x0_wen got %0h want 0", wq.wb_wen); end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 5'd1, 32'h100, 1'b1);
        cycle(1'b1, 5'd2, 32'h101, 1'b1);
        n_vec++; if (wq.count !== 4'd2) begin n_err++; $display("FAIL b2b_pre_count got %0d want 2", wq.count); end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 5'((i % 29) + 3), 32'h102 + 32'(i), 1'b0);
            n_vec++; if (wq.count !== 4'd2) begin n_err++; $display("FAIL b2b_count[%0d] got %0d want 2", i, wq.count); end
            n_vec++; if (wq.wb_wen !== 1'b1) begin n_err++; $display("FAIL b2b_wen[%0d] got %0h want 1", i, wq.wb_wen); end
            n_vec++; if (wq.wb_din !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL b2b_din[%0d] got %0h want %0h", i, wq.wb_din, 32'h100 + 32'(i)); end
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if (wq.count !== 4'd0) begin n_err++; $display("FAIL b2b_drain_count got %0d want 0", wq.count); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) cycle(1'b1, 5'(k + 9), 32'hC0 + 32'(k), 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0);
        wq.wb_stall = 1'b1;
        n_vec++; if (wq.count !== 4'd3) begin n_err++; $display("FAIL rstmid_pre_count got %0d want 3", wq.count); end
        n_vec++; if (wq.wb_wen !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_wen got %0h want 1", wq.wb_wen); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++; if (wq.wb_wen !== 1'b0) begin n_err++; $display("FAIL rstmid_wen got %0h want 0", wq.wb_wen); end
        n_vec++; if (wq.count !== 4'd0) begin n_err++; $display("FAIL rstmid_count got %0d want 0", wq.count); end
        n_vec++; if (wq.pend !== 32'd0) begin n_err++; $display("FAIL rstmid_pend got %0h want 0", wq.pend); end
        n_vec++; if (wq.in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %0h want 1", wq.in_ready); end
        #4 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0);
            n_vec++; if (wq.wb_wen !== 1'b0) begin n_err++; $display("FAIL rstmid_post_wen[%0d] got %0h want 0", i, wq.wb_wen); end
            n_vec++; if (wq.count !== 4'd0) begin n_err++; $display("FAIL rstmid_post_count[%0d] got %0d want 0", i, wq.count); end
        end
    endtask

`ifdef WB_FWD_EN
    task automatic test_forwarding();
        cycle(1'b1, 5'd7, 32'hA, 1'b1);
        cycle(1'b1, 5'd7, 32'hB, 1'b1);
        fwd_rs1 = 5'd7;
        fwd_rs2 = 5'd0;
        #1;
        n_vec++; if (fwd_hit1 !== 1'b1) begin n_err++; $display("FAIL fwd_hit1 got %0h want 1", fwd_hit1); end
        n_vec++; if (fwd_data1 !== 32'hB) begin n_err++; $display("FAIL fwd_data1 got %0h want b", fwd_data1); end
        n_vec++; if (fwd_hit2 !== 1'b0) begin n_err++; $display("FAIL fwd_hit2_x0 got %0h want 0", fwd_hit2); end
        n_vec++; if (fwd_data2 !== 32'h0) begin n_err++; $display("FAIL fwd_data2_x0 got %0h want 0", fwd_data2); end
        fwd_rs2 = 5'd9;
        #1;
        n_vec++; if (fwd_hit2 !== 1'b0) begin n_err++; $display("FAIL fwd_hit2_miss got %0h want 0", fwd_hit2); end
        cycle(1'b0, 5'd0, 32'd0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if (fwd_hit1 !== 1'b1) begin n_err++; $display("FAIL fwd_out_hit got %0h want 1", fwd_hit1); end
        n_vec++; if (fwd_data1 !== 32'hB) begin n_err++; $display("FAIL fwd_out_data got %0h want b", fwd_data1); end
        cycle(1'b0, 5'd0, 32'd0, 1'b0);
        n_vec++; if (fwd_hit1 !== 1'b0) begin n_err++; $display("FAIL fwd_drained_hit got %0h want 0", fwd_hit1); end
        fwd_rs1 = 5'd0;
        fwd_rs2 = 5'd0;
    endtask
`endif

    task automatic test_random();
        logic        v;
        logic        st;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [31:0] ep;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) == 0) ? 5'd3 : 5'($urandom_range(0, 31));
            d  = $urandom;
            st = (i < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
`ifdef WB_FWD_EN
            fwd_rs1 = 5'($urandom_range(0, 31));
            fwd_rs2 = ($urandom_range(0, 1) == 0) ? 5'd3 : 5'($urandom_range(0, 31));
`endif
            cycle(v, rd, d, st);
            ep = model_pend();
            n_vec++; if (wq.wb_wen !== m_wen) begin n_err++; $display("FAIL rnd_wen[%0d] got %0h want %0h", i, wq.wb_wen, m_wen); end
            n_vec++; if (wq.wb_rd !== m_rd) begin n_err++; $display("FAIL rnd_rd[%0d] got %0d want %0d", i, wq.wb_rd, m_rd); end
            n_vec++; if (wq.wb_din !== m_din) begin n_err++; $display("FAIL rnd_din[%0d] got %0h want %0h", i, wq.wb_din, m_din); end
            n_vec++; if (wq.count !== 4'(exp_q.size())) begin n_err++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, wq.count, exp_q.size()); end
            n_vec++; if (wq.in_ready !== (exp_q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready[%0d] got %0h want %0h", i, wq.in_ready, exp_q.size() < DEPTH); end
            n_vec++; if (wq.pend !== ep) begin n_err++; $display("FAIL rnd_pend[%0d] got %0h want %0h", i, wq.pend, ep); end
`ifdef WB_FWD_EN
            n_vec++; if ({fwd_hit1, fwd_data1} !== model_fwd(fwd_rs1)) begin n_err++; $display("FAIL rnd_fwd1[%0d] got %0h want %0h", i, {fwd_hit1, fwd_data1}, model_fwd(fwd_rs1)); end
            n_vec++; if ({fwd_hit2, fwd_data2} !== model_fwd(fwd_rs2)) begin n_err++; $display("FAIL rnd_fwd2[%0d] got %0h want %0h", i, {fwd_hit2, fwd_data2}, model_fwd(fwd_rs2)); end
`endif
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_single_write();
        test_fill_order();
        test_x0_drop();
        test_back_to_back();
        test_reset_mid();
`ifdef WB_FWD_EN
        test_forwarding();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; the SHALL range is 2..8 and the value SHALL be a power of two.
REQ-002 Parameter XLEN, default 32, data width of each register-file write.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  the execute stage is offering a result.
REQ-006 in_ready  output  1  the queue can accept a result this cycle.
REQ-007 in_rd  input  5  destination register of the offered result.
REQ-008 in_data  input  XLEN  offered result data.
REQ-009 wb_stall  input  1  the register-file write port is unavailable this cycle.
REQ-010 wb_wen  output  1  register-file write enable, driven from a register.
REQ-011 wb_rd  output  5  register-file write address, driven from a register.
REQ-012 wb_din  output  XLEN  register-file write data, driven from a register.
REQ-013 pend  output  32  scoreboard; bit r SHALL be high while any queued entry or the output stage targets register r.
REQ-014 count  output  4  number of valid queue entries, excluding the output stage.

Function
REQ-015 A push SHALL occur on a rising edge when in_valid=1, in_ready=1 and in_rd!=0.
REQ-016 When in_rd=0 and in_valid=1, the handshake SHALL complete but nothing SHALL be enqueued.
REQ-017 in_ready SHALL equal (count<DEPTH).
REQ-018 There SHALL be no combinational path from in_valid to in_ready.
REQ-019 When full, no bypass SHALL occur, even if a pop happens in the same cycle.
REQ-020 A pop SHALL occur on a rising edge when count>0 and wb_stall=0; the head entry SHALL be loaded into wb_rd/wb_din and wb_wen SHALL be set to 1.
REQ-021 When no pop occurs on a rising edge, wb_wen SHALL be 0 after that edge; wb_rd and wb_din SHALL hold their previous values.
REQ-022 Each wb_wen pulse SHALL last exactly one cycle per entry.
REQ-023 Latency: an entry pushed at edge k into an empty queue, with wb_stall=0, SHALL appear on wb_* (wb_wen=1) after edge k+1.
REQ-024 Order: entries SHALL be written back in strict push order, including entries with the same in_rd.
REQ-025 The read and write pointers SHALL be modulo DEPTH and wrap without loss.
REQ-026 A push and a pop on the same edge SHALL leave count unchanged.
REQ-027 pend SHALL be computed combinationally from the entry-valid bits, the entry rd fields and the output stage (wb_wen, wb_rd).
REQ-028 pend[0] SHALL always be 0.
REQ-029 A pend bit SHALL clear only when no entry and no output stage still targets that register.
REQ-030 count SHALL never exceed DEPTH and never go below 0.

Reset
REQ-031 While rst_n=0, count, the pointers and all entry-valid bits SHALL be 0, and the following outputs SHALL be: wb_wen=0, wb_rd=0, wb_din=0, pend=0, in_ready=1.
REQ-032 Reset SHALL take effect immediately, without waiting for clk.
REQ-033 An assertion of rst_n mid-operation SHALL discard all queued entries and any in-flight write; no wb_wen pulse SHALL follow the deassertion of rst_n without a new push.
REQ-034 Entry data storage SHALL NOT need to be reset; stale data SHALL never be observable.

Configuration
REQ-035 Macro WB_FWD_EN.
When defined, the block SHALL add the following ports:
- fwd_rs1  input  5
- fwd_rs2  input  5
- fwd_hit1  output  1
- fwd_hit2  output  1
- fwd_data1  output  XLEN
- fwd_data2  output  XLEN
REQ-036 With WB_FWD_EN defined, fwd_hitN SHALL be 1 when fwd_rsN!=0 and fwd_rsN matches a valid queue entry or the output stage; fwd_dataN SHALL be the data of the youngest match, checked in the order queue tail first, then the output stage last; fwd_dataN SHALL be 0 on a miss; the lookup SHALL be combinational.
REQ-037 Without WB_FWD_EN, these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-038 Scenario, single write: push rd=5, data=0xDEADBEEF at edge 1 with wb_stall=0 -> after edge 2, wb_wen=1, wb_rd=5, wb_din=0xDEADBEEF; after edge 3, wb_wen=0; pend[5] is high from edge 1 until edge 3.
REQ-039 Scenario, fill and order: hold wb_stall=1 and push rd=1..5 with data=0x11..0x55 -> in_ready drops after the 4th push and count=4; then release wb_stall -> writes rd 1,2,3,4 in order, one per cycle.
REQ-040 Scenario, x0 drop: push rd=0, data=0x1234 -> handshake completes, count stays 0, no wb_wen, pend=0.
REQ-041 Scenario, simultaneous push/pop and wrap: with count=2, push and pop every cycle for 10 cycles with incrementing data -> count stays 2; writeback data is the input sequence delayed, in order.
REQ-042 Scenario, reset mid-operation: with count=3 and wb_stall=1, pulse rst_n low for half a cycle -> wb_wen=0, count=0, pend=0 immediately; after release, no writes occur.
REQ-043 Scenario, forwarding (WB_FWD_EN defined): queue holds rd=7 with data 0xA then rd=7 with data 0xB; fwd_rs1=7 -> fwd_hit1=1, fwd_data1=0xB; fwd_rs2=0 -> fwd_hit2=0.
